// File: rtl/retro_memory_port_arbiter.sv
// retro_memory_port_arbiter
//
// Two-initiator to one-target arbiter for a simple handshake memory port.
// Requests travel combinationally from the winning initiator to the shared
// target. Every read that is accepted pushes the ID of its issuing initiator
// into a small tag FIFO. Each read return (m_data_ready) pops one tag, and the
// return is steered only to the initiator named by that tag. Because the FIFO
// is in-order, returns reach the initiators in the same order as the reads
// were issued.
//
// Optional feature: RETRO_MEMORY_ARB_ROUND_ROBIN_EN
//   defined   - on contention the initiator that did not win the last
//               transfer is granted (tracked in the 'last' register).
//   undefined - initiator 0 always wins contention; there is no 'last'.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   i0_* / i1_*                upstream initiator ports
//     access, address, din, write   request from initiator (din = write data)
//     ready                         request accepted when access & ready
//     data_ready, dout              read return strobe and read data
//   m_*                        downstream target port
//     access, address, dout, write  request to target (dout = write data)
//     ready                         target can accept a request
//     data_ready, din               read return strobe and read data
//   underflow                  sticky: a return arrived with no read in flight
module retro_memory_port_arbiter #(
    parameter int AddressBusWidth  = 16,
    parameter int DataBusWidth     = 8,
    parameter int OutstandingDepth = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       i0_access,
    input  logic [AddressBusWidth-1:0] i0_address,
    input  logic [DataBusWidth-1:0]    i0_din,
    input  logic                       i0_write,
    output logic                       i0_ready,
    output logic                       i0_data_ready,
    output logic [DataBusWidth-1:0]    i0_dout,

    input  logic                       i1_access,
    input  logic [AddressBusWidth-1:0] i1_address,
    input  logic [DataBusWidth-1:0]    i1_din,
    input  logic                       i1_write,
    output logic                       i1_ready,
    output logic                       i1_data_ready,
    output logic [DataBusWidth-1:0]    i1_dout,

    output logic                       m_access,
    output logic [AddressBusWidth-1:0] m_address,
    output logic [DataBusWidth-1:0]    m_dout,
    output logic                       m_write,
    input  logic                       m_ready,
    input  logic                       m_data_ready,
    input  logic [DataBusWidth-1:0]    m_din,

    output logic                       underflow
);

    localparam int PtrW   = $clog2(OutstandingDepth);
    localparam int CountW = PtrW + 1;

    logic [OutstandingDepth-1:0] tag_mem;
    logic [PtrW-1:0]             wr_ptr;
    logic [PtrW-1:0]             rd_ptr;
    logic [CountW-1:0]           count;

    logic tag_full;
    logic prefer_i0;
    logic grant0, grant1;
    logic can_issue;
    logic xfer0, xfer1;
    logic push, pop, push_id, head_id;

    // Full is taken from the registered count only, so a pop in the same
    // cycle never frees a slot for a push until the next cycle.
    assign tag_full = (count == CountW'(OutstandingDepth));

`ifdef RETRO_MEMORY_ARB_ROUND_ROBIN_EN
    logic last;
    // Grant the initiator that is not the last winner.
    assign prefer_i0 = last;
`else
    assign prefer_i0 = 1'b1;
`endif

    assign grant0 = i0_access & (~i1_access | prefer_i0);
    assign grant1 = i1_access & (~i0_access | ~prefer_i0);

    // Ready is gated with reset so nothing is accepted while in reset.
    assign can_issue = reset & m_ready & ~tag_full;
    assign i0_ready  = can_issue & (grant0 | ~i1_access);
    assign i1_ready  = can_issue & (grant1 | ~i0_access);

    assign xfer0 = i0_access & i0_ready;
    assign xfer1 = i1_access & i1_ready;

    // Zero-latency request mux; at most one xfer is ever high.
    assign m_access  = xfer0 | xfer1;
    assign m_address = xfer1 ? i1_address : i0_address;
    assign m_dout    = xfer1 ? i1_din     : i0_din;
    assign m_write   = xfer1 ? i1_write   : i0_write;

    assign push    = (xfer0 & ~i0_write) | (xfer1 & ~i1_write);
    assign push_id = xfer1;

    assign pop     = reset & m_data_ready & (count != '0);
    assign head_id = tag_mem[rd_ptr];

    assign i0_data_ready = pop & ~head_id;
    assign i1_data_ready = pop &  head_id;
    assign i0_dout       = m_din;
    assign i1_dout       = m_din;

    // Pointers are PtrW bits wide and the depth is a power of two, so the
    // natural overflow gives the modulo-depth wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= push_id;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CountW'(push) - CountW'(pop);
            if (m_data_ready && count == '0)
                underflow <= 1'b1;
        end
    end

`ifdef RETRO_MEMORY_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!reset)
            last <= 1'b1;
        else if (xfer0 | xfer1)
            last <= xfer1;
    end
`endif

endmodule

// File: tb/tb_retro_memory_port_arbiter.sv
module tb_retro_memory_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic i0_access, i0_write, i0_ready, i0_data_ready;
    logic [AW-1:0] i0_address;
    logic [DW-1:0] i0_din, i0_dout;
    logic i1_access, i1_write, i1_ready, i1_data_ready;
    logic [AW-1:0] i1_address;
    logic [DW-1:0] i1_din, i1_dout;
    logic m_access, m_write, m_ready, m_data_ready, underflow;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_dout, m_din;

    always #5 clk = ~clk;

    retro_memory_port_arbiter #(
        .AddressBusWidth(AW), .DataBusWidth(DW), .OutstandingDepth(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .i0_access(i0_access), .i0_address(i0_address), .i0_din(i0_din),
        .i0_write(i0_write), .i0_ready(i0_ready), .i0_data_ready(i0_data_ready),
        .i0_dout(i0_dout),
        .i1_access(i1_access), .i1_address(i1_address), .i1_din(i1_din),
        .i1_write(i1_write), .i1_ready(i1_ready), .i1_data_ready(i1_data_ready),
        .i1_dout(i1_dout),
        .m_access(m_access), .m_address(m_address), .m_dout(m_dout),
        .m_write(m_write), .m_ready(m_ready), .m_data_ready(m_data_ready),
        .m_din(m_din), .underflow(underflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of initiator IDs for reads in flight.
    bit q[$];
    bit mdl_underflow = 1'b0;
    bit mdl_last = 1'b1;
`ifdef RETRO_MEMORY_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    bit e_r0, e_r1, e_t0, e_t1, e_pop, e_dr0, e_dr1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample at the falling edge and compare everything against the model.
    task automatic half();
        bit full, winner;
        @(negedge clk);
        full   = (q.size() == DEPTH);
        winner = (i0_access && i1_access) ? (RR ? ~mdl_last : 1'b0) : i1_access;
        e_r0  = reset && m_ready && !full && (!i1_access || (i0_access && winner == 1'b0));
        e_r1  = reset && m_ready && !full && (!i0_access || (i1_access && winner == 1'b1));
        e_t0  = i0_access && e_r0;
        e_t1  = i1_access && e_r1;
        e_pop = reset && m_data_ready && q.size() > 0;
        e_dr0 = e_pop && q[0] == 1'b0;
        e_dr1 = e_pop && q[0] == 1'b1;
        chk("i0_ready", i0_ready, e_r0);
        chk("i1_ready", i1_ready, e_r1);
        chk("m_access", m_access, e_t0 || e_t1);
        if (e_t0 || e_t1) begin
            chk("m_address", m_address, e_t1 ? i1_address : i0_address);
            chk("m_dout", m_dout, e_t1 ? i1_din : i0_din);
            chk("m_write", m_write, e_t1 ? i1_write : i0_write);
        end
        chk("i0_data_ready", i0_data_ready, e_dr0);
        chk("i1_data_ready", i1_data_ready, e_dr1);
        chk("i0_dout", i0_dout, m_din);
        chk("i1_dout", i1_dout, m_din);
        chk("underflow", underflow, mdl_underflow);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            q.delete();
            mdl_underflow = 1'b0;
            mdl_last = 1'b1;
        end else begin
            if (m_data_ready && q.size() == 0) mdl_underflow = 1'b1;
            if (e_pop) void'(q.pop_front());
            if (e_t0 && !i0_write) q.push_back(1'b0);
            if (e_t1 && !i1_write) q.push_back(1'b1);
            if (e_t0 || e_t1) mdl_last = e_t1;
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b1;
        i0_access = 0; i0_write = 0; i0_address = '0; i0_din = '0;
        i1_access = 0; i1_write = 0; i1_address = '0; i1_din = '0;
        m_ready = 1'b1; m_data_ready = 1'b0; m_din = '0;
    endtask

    task automatic cyc();
        half();
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(posedge clk); #1;
        q.delete();
        // reset holds ready low even with a request pending
        i0_access = 1; i1_access = 1; m_data_ready = 1;
        half();
        chk("rst_i0_ready", i0_ready, 1'b0);
        chk("rst_m_access", m_access, 1'b0);
        tick();

        // Single read from I0, return two cycles later.
        idle();
        i0_access = 1; i0_address = 16'h1234;
        half();
        chk("lit_first_ready", i0_ready, 1'b1);
        chk("lit_addr", m_address, 16'h1234);
        tick();
        idle(); cyc();
        m_data_ready = 1; m_din = 8'h5A;
        half();
        chk("lit_i0_dr", i0_data_ready, 1'b1);
        chk("lit_i0_dout", i0_dout, 8'h5A);
        chk("lit_i1_dr", i1_data_ready, 1'b0);
        tick();

        // Return with nothing outstanding -> sticky underflow.
        half();
        chk("lit_no_dr", i0_data_ready, 1'b0);
        tick();
        idle();
        half(); chk("lit_uf_set", underflow, 1'b1); tick();
        half(); chk("lit_uf_hold", underflow, 1'b1); tick();
        reset = 0; cyc(); reset = 1;
        half(); chk("lit_uf_clr", underflow, 1'b0); tick();

        // Fill the tag FIFO; a pop in the full cycle does not admit a push.
        for (int k = 0; k < DEPTH; k++) begin
            i0_access = 1; i0_address = AW'(k);
            cyc();
        end
        m_data_ready = 1;
        half();
        chk("lit_full_r0", i0_ready, 1'b0);
        chk("lit_full_r1", i1_ready, 1'b0);
        chk("lit_full_pop", i0_data_ready, 1'b1);
        tick();
        m_data_ready = 0;
        half(); chk("lit_after_pop", i0_ready, 1'b1); tick();
        idle();
        for (int k = 0; k < DEPTH; k++) begin m_data_ready = 1; cyc(); end
        idle();

        // Read, write, read: only two tags queued.
        i0_access = 1; cyc();
        idle(); i1_access = 1; i1_write = 1; i1_din = 8'hC3;
        half();
        chk("lit_wr_pass", m_write, 1'b1);
        chk("lit_wr_data", m_dout, 8'hC3);
        tick();
        idle(); i0_access = 1; cyc();
        idle(); m_data_ready = 1;
        cyc(); cyc();
        half(); chk("lit_third_pop", i0_data_ready | i1_data_ready, 1'b0); tick();
        idle(); reset = 0; cyc(); idle();

`ifdef RETRO_MEMORY_ARB_ROUND_ROBIN_EN
        i0_access = 1; i1_access = 1;
        half(); chk("lit_rr_first", {i0_ready, i1_ready}, 2'b10); tick();
        half(); chk("lit_rr_second", {i0_ready, i1_ready}, 2'b01); tick();
        idle(); m_data_ready = 1;
        half(); chk("lit_rr_ret0", {i0_data_ready, i1_data_ready}, 2'b10); tick();
        half(); chk("lit_rr_ret1", {i0_data_ready, i1_data_ready}, 2'b01); tick();
`else
        i0_access = 1; i1_access = 1;
        for (int k = 0; k < 3; k++) begin
            half(); chk("lit_fix_grant", {i0_ready, i1_ready}, 2'b10); tick();
        end
        idle(); m_data_ready = 1;
        for (int k = 0; k < 3; k++) begin
            half(); chk("lit_fix_ret", {i0_data_ready, i1_data_ready}, 2'b10); tick();
        end
`endif
        idle(); reset = 0; cyc(); idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 199) != 0);
            i0_access    = ($urandom_range(0, 1) == 1);
            i1_access    = ($urandom_range(0, 1) == 1);
            i0_write     = ($urandom_range(0, 9) < 3);
            i1_write     = ($urandom_range(0, 9) < 3);
            i0_address   = AW'($urandom);
            i1_address   = AW'($urandom);
            i0_din       = DW'($urandom);
            i1_din       = DW'($urandom);
            m_ready      = ($urandom_range(0, 99) < 85);
            m_data_ready = ($urandom_range(0, 99) < 40);
            m_din        = DW'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
